// File: rtl/regfile_dump_reader.sv
// Debug read-out master: walks register addresses FIRST_REG..LAST_REG over a spare
// asynchronous read port and offers each captured word downstream, then pulses Done.
module regfile_dump_reader #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Abort,
    output logic [4:0]  RdAddr,
    input  logic [31:0] RdData,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [4:0]  OutAddr,
    output logic [31:0] OutData,
    output logic        Busy,
    output logic        Done,
    output logic [1:0]  DbgState
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } stateT;

    localparam logic [4:0] FirstAddr = 5'(FIRST_REG);
    localparam logic [4:0] LastAddr  = 5'(LAST_REG);

    stateT      state;
    logic [4:0] addrCnt;

    // The counter drives the read port directly, so RdAddr holds its last value outside READ.
    assign RdAddr   = addrCnt;
    assign Busy     = (state != IDLE);
    assign Done     = (state == DONE);
    assign DbgState = state;

    // Output handshake: a word transfers in any cycle with OutValid & OutReady;
    // OutAddr/OutData are held stable from OutValid rising until that cycle.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= IDLE;
            addrCnt  <= '0;
            OutValid <= 1'b0;
            OutAddr  <= '0;
            OutData  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        addrCnt <= FirstAddr;
                        state   <= READ;
                    end
                end
                READ: begin
                    if (Abort) begin
                        state <= IDLE;
                    end else begin
                        OutData  <= RdData;
                        OutAddr  <= addrCnt;
                        OutValid <= 1'b1;
                        state    <= PRESENT;
                    end
                end
                PRESENT: begin
                    // Abort wins over a same-cycle handshake: the dump ends without Done.
                    if (Abort) begin
                        OutValid <= 1'b0;
                        state    <= IDLE;
                    end else if (OutReady) begin
                        OutValid <= 1'b0;
                        if (addrCnt == LastAddr) begin
                            state <= DONE;
                        end else begin
                            addrCnt <= addrCnt + 5'd1;
                            state   <= READ;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Debug read-out master for the CPU's 32×32 register file. When `Start` is pulsed it walks register addresses `FIRST_REG`..`LAST_REG` over a spare asynchronous read port. It captures each word and offers it downstream (display or serial debug sink) over a valid/ready handshake, then pulses `Done`. It is the reading counterpart to the register file's write side: it never writes, and it only drives a read address.

## Interface
- `FIRST_REG`, default 0: first address dumped (0..31).
- `LAST_REG`, default 31: last address dumped; `FIRST_REG <= LAST_REG` is required, and the design does not check it.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `Reset`  in  1  reset, synchronous and active-high.
- `Start`  in  1  dump request, sampled in IDLE only.
- `Abort`  in  1  cancels a dump in progress.
- `RdAddr`  out  5  read address to the register-file port.
- `RdData`  in  32  combinational read data for `RdAddr`, valid in the same cycle.
- `OutValid`  out  1  `OutAddr`/`OutData` hold a word.
- `OutReady`  in  1  sink accepts the word.
- `OutAddr`  out  5  register number of the offered word.
- `OutData`  out  32  register contents.
- `Busy`  out  1  high whenever state ≠ IDLE.
- `Done`  out  1  one-cycle pulse after the last word is accepted.

## Operation
- FSM states are IDLE, READ, PRESENT and DONE. All outputs are registered or decoded from state. There is no combinational path from any input to any output.
- **IDLE**
  - `Start`=1 loads the address counter with `FIRST_REG` and moves to READ.
  - `Start` in any other state is ignored; it is not queued.
- **READ** (one cycle)
  - `RdAddr` = counter.
  - At the clock edge, `OutData` ← `RdData`, `OutAddr` ← counter, `OutValid` ← 1, and the FSM moves to PRESENT.
- **PRESENT**
  - `OutValid`=1. `OutAddr` and `OutData` stay stable until the handshake completes, i.e. a cycle with `OutValid`&`OutReady`.
  - On handshake:
    - If counter = `LAST_REG`: `OutValid` ← 0, go to DONE.
    - Otherwise: counter ← counter+1, `OutValid` ← 0, go to READ.
  - If `OutReady`=0, the FSM stays in PRESENT indefinitely.
- **DONE** (one cycle)
  - `Done`=1, then go to IDLE.
- **Snapshot semantics:** each word reflects the register contents at the edge ending its READ cycle. A register-file write after that edge is not reflected in the word already captured. A write before that edge is reflected.
- **Abort:** in READ, PRESENT or DONE, `Abort`=1 forces IDLE at the next edge.
  - `OutValid` ← 0 and `Done` is not pulsed.
  - If `Abort` and `OutReady` both arrive in the same PRESENT cycle, `Abort` wins. The word counts as accepted by the sink, but the dump still ends without `Done`.
- **Counter:** 5-bit. It never wraps, because `LAST_REG` ≤ 31 stops the walk first.
- `RdAddr` holds its last value outside READ. The reader places no requirement on the port when it is not reading.

## Timing
- **Reset** (synchronous; dominates `Start` and `Abort`) sets:
  - state = IDLE
  - `RdAddr`=0, `OutAddr`=0, `OutData`=0
  - `OutValid`=0, `Busy`=0, `Done`=0
- **Reset mid-dump:** outputs reach the reset values at the first edge with `Reset`=1. No `Done` is produced.
- **Cycle numbering:** call the cycle in which `Start` is sampled high in IDLE cycle 0.
  - READ occurs in cycle 1.
  - The first word is valid from cycle 2.
- **Throughput:** with `OutReady` held high, word i is valid during cycle 2+2i, giving one word per 2 cycles.
- **Completion:** with N = `LAST_REG`−`FIRST_REG`+1 and `OutReady` held high:
  - `Done` is high in cycle 2N+1.
  - `Busy` is high in cycles 1..2N+1.
  - IDLE resumes in cycle 2N+2.
  - With the defaults, `Done` is high in cycle 65.
- **Back-to-back dumps:** a `Start` in the same cycle as `Done` is ignored. The earliest accepted restart is cycle 2N+2.
- **Backpressure:** each cycle of `OutReady`=0 in PRESENT adds exactly one cycle to the dump.

## Test plan
- **Full dump:** preload r_k = 0x1000_0000+k for k=1..31 (r0=0), hold `OutReady`=1 and pulse `Start`.
  - Expect 32 handshakes, `OutAddr`=0..31 in order, with `OutData` matching r_k.
  - Expect `Done` exactly in cycle 65 and `Busy` high in cycles 1..65.
- **Backpressure:** set `FIRST_REG`=3, `LAST_REG`=5 and toggle `OutReady` 0,0,1 per word.
  - Expect `OutData` stable across stall cycles and 3 words (addr 3,4,5).
  - Expect `Done` in cycle 2·3+1+6 = 13.
- **Snapshot:** during PRESENT for addr 7, write r7 ← 0xDEAD_BEEF.
  - The offered word stays at the old r7 value.
  - A second dump returns 0xDEAD_BEEF for addr 7.
- **Abort:** assert `Abort` in PRESENT for addr 10 with `OutReady`=1.
  - Next cycle: `OutValid`=0, `Busy`=0, and no `Done`.
  - A subsequent `Start` restarts from addr 0.
- **Reset and Start while busy:** pulse `Start` in cycles 5 and 30 of a dump, then assert `Reset` in cycle 20 of a second dump.
  - The extra Starts cause no restart and no address skip.
  - After `Reset`, all outputs are 0 at the next edge and `Done` never fires.
